// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule,
// controller state type, widths and a 28-bit rotate helper.
// Bit numbering is big-endian: index 0 is DES bit 1.
package des_pkg;

    localparam int DES_KEY_W  = 64;
    localparam int DES_HALF_W = 28;
    localparam int DES_RKEY_W = 48;

    // PC-1: entry i gives the 0-based key bit feeding C/D bit i (C = 0..27, D = 28..55).
    localparam int PC1_TAB [56] = '{
        56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
    };

    // PC-2: entry i gives the 0-based C/D bit feeding round-key bit i.
    localparam int PC2_TAB [48] = '{
        13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
        22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
        40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
        43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
    };

    // Left shifts applied entering rounds 1..16 (index 0 = round 1).
    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } des_ks_state_t;

    // Rotate a 28-bit half by 0..2 positions; right=1 rotates toward higher indices.
    function automatic logic [0:27] rot28(input logic [0:27] v,
                                          input logic [1:0]  amt,
                                          input logic        right);
        logic [0:27] r;
        r = v;
        if (right) begin
            case (amt)
                2'd1:    r = {v[27], v[0:26]};
                2'd2:    r = {v[26:27], v[0:25]};
                default: r = v;
            endcase
        end else begin
            case (amt)
                2'd1:    r = {v[1:27], v[0]};
                2'd2:    r = {v[2:27], v[0:1]};
                default: r = v;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Handshake bundle between the DES engine and the key schedule.
// decrypt_din exists only when DES_DECRYPT_EN is defined.
interface des_key_schedule_if;
    import des_pkg::*;

    logic                    start_strobe_din;
    logic [0:DES_KEY_W-1]    key_din;
`ifdef DES_DECRYPT_EN
    logic                    decrypt_din;
`endif
    logic                    round_advance_din;
    logic [0:DES_RKEY_W-1]   round_key_dout;
    logic                    round_key_valid_dout;
    logic [3:0]              round_number_dout;
    logic                    busy_dout;
    logic                    done_dout;

    modport master (
        output start_strobe_din,
        output key_din,
`ifdef DES_DECRYPT_EN
        output decrypt_din,
`endif
        output round_advance_din,
        input  round_key_dout,
        input  round_key_valid_dout,
        input  round_number_dout,
        input  busy_dout,
        input  done_dout
    );

    modport slave (
        input  start_strobe_din,
        input  key_din,
`ifdef DES_DECRYPT_EN
        input  decrypt_din,
`endif
        input  round_advance_din,
        output round_key_dout,
        output round_key_valid_dout,
        output round_number_dout,
        output busy_dout,
        output done_dout
    );

endinterface

// File: rtl/des_pc2.sv
// PC-2 permutation: 56-bit C/D concatenation to a 48-bit round key.
// Pure combinational; shared with unrolled engine variants.
module des_pc2
    import des_pkg::*;
(
    input  logic [0:2*DES_HALF_W-1] cd_i,
    output logic [0:DES_RKEY_W-1]   rkey_o
);

    for (genvar g = 0; g < DES_RKEY_W; g++) begin : g_pc2
        assign rkey_o[g] = cd_i[PC2_TAB[g][5:0]];
    end

    // PC-2 drops these eight C/D bits by design.
    logic unused_cd_bits;
    assign unused_cd_bits = ^{cd_i[8], cd_i[17], cd_i[21], cd_i[24],
                              cd_i[34], cd_i[37], cd_i[42], cd_i[53]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator: loads a key through PC-1 and presents
// the sixteen round keys one per accepted advance.
// Optional feature: DES_DECRYPT_EN adds decrypt_din and reverse-order keys.
module des_key_schedule
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    des_key_schedule_if.slave ks
);

    des_ks_state_t          state_q, state_d;
    logic [0:DES_HALF_W-1]  c_q, c_d;
    logic [0:DES_HALF_W-1]  d_q, d_d;
    logic [3:0]             round_q, round_d;
    logic                   done_q, done_d;
    logic                   dec_q;
`ifdef DES_DECRYPT_EN
    logic                   dec_d;
`endif

    logic [0:2*DES_HALF_W-1] pc1_key;
    logic [1:0]              shift_amt;
    logic [3:0]              round_inc;

    for (genvar g = 0; g < 2 * DES_HALF_W; g++) begin : g_pc1
        assign pc1_key[g] = ks.key_din[PC1_TAB[g][5:0]];
    end

    // Parity bits never reach PC-1.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{ks.key_din[7],  ks.key_din[15], ks.key_din[23],
                                  ks.key_din[31], ks.key_din[39], ks.key_din[47],
                                  ks.key_din[55], ks.key_din[63]};

    assign round_inc = round_q + 4'd1;

    // Decrypt walks the encrypt schedule backwards: entering 0-based round n
    // uses the encrypt shift at index 16-n, i.e. 15-round_q.
`ifdef DES_DECRYPT_EN
    assign shift_amt = dec_q ? SHIFT_TAB[4'd15 - round_q][1:0]
                             : SHIFT_TAB[round_inc][1:0];
`else
    assign shift_amt = SHIFT_TAB[round_inc][1:0];
`endif

    // Register update: all control and key state cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
`ifdef DES_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            done_q  <= done_d;
`ifdef DES_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

`ifndef DES_DECRYPT_EN
    assign dec_q = 1'b0;
`endif

    // Next-state: load on start in IDLE, step C/D on each advance in ACTIVE.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        done_d  = 1'b0;
`ifdef DES_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (ks.start_strobe_din) begin
`ifdef DES_DECRYPT_EN
                    dec_d = ks.decrypt_din;
                    if (ks.decrypt_din) begin
                        c_d = pc1_key[0:27];
                        d_d = pc1_key[28:55];
                    end else begin
                        c_d = rot28(pc1_key[0:27],  2'd1, 1'b0);
                        d_d = rot28(pc1_key[28:55], 2'd1, 1'b0);
                    end
`else
                    c_d = rot28(pc1_key[0:27],  2'd1, 1'b0);
                    d_d = rot28(pc1_key[28:55], 2'd1, 1'b0);
`endif
                    round_d = 4'd0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ks.round_advance_din) begin
                    if (round_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        c_d     = '0;
                        d_d     = '0;
                        round_d = 4'd0;
                    end else begin
                        round_d = round_inc;
                        c_d     = rot28(c_q, shift_amt, dec_q);
                        d_d     = rot28(d_q, shift_amt, dec_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    des_pc2 u_pc2 (
        .cd_i   ({c_q, d_q}),
        .rkey_o (ks.round_key_dout)
    );

    assign ks.round_key_valid_dout = (state_q == ACTIVE);
    assign ks.busy_dout            = (state_q == ACTIVE);
    assign ks.round_number_dout    = round_q;
    assign ks.done_dout            = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed protocol cases plus randomized traffic
// against a behavioural DES key-schedule model.
module tb_des_key_schedule;

    logic clk;
    logic reset;

    des_key_schedule_if ifc ();

    des_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Standard DES tables, 1-based as in FIPS 46.
    localparam int PC1 [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int PC2 [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    int nvec = 0;
    int nerr = 0;

    // Encrypt-order round key r (0-based) computed from scratch.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] o;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1[i]];
            d[27-i] = k[64-PC1[28+i]];
        end
        for (int j = 0; j <= r; j++)
            for (int s = 0; s < SH[j]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state.
    bit          model_ok = 1'b0;
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_dec    = 1'b0;
    int          m_round  = 0;
    logic [47:0] mk [16];

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_round  = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (ifc.start_strobe_din) begin
                    for (int r = 0; r < 16; r++) mk[r] = ref_key(ifc.key_din, r);
`ifdef DES_DECRYPT_EN
                    m_dec = ifc.decrypt_din;
`else
                    m_dec = 1'b0;
`endif
                    m_active = 1'b1;
                    m_round  = 0;
                end
            end else if (ifc.round_advance_din) begin
                if (m_round == 15) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_round  = 0;
                end else begin
                    m_round++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            logic [47:0] ek;
            ek = !m_active ? 48'h0 : (m_dec ? mk[15-m_round] : mk[m_round]);
            chk("valid", 64'(ifc.round_key_valid_dout), 64'(m_active));
            chk("busy",  64'(ifc.busy_dout),            64'(m_active));
            chk("done",  64'(ifc.done_dout),            64'(m_done));
            chk("round", 64'(ifc.round_number_dout),    64'(m_round));
            chk("key",   64'(ifc.round_key_dout),       64'(ek));
        end
    end

    task automatic idle_inputs();
        ifc.start_strobe_din  = 1'b0;
        ifc.round_advance_din = 1'b0;
`ifdef DES_DECRYPT_EN
        ifc.decrypt_din       = 1'b0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        ifc.key_din = '0;
        idle_inputs();

        // Pin the model against published vectors.
        chk("model_k1",  64'(ref_key(KEY_A, 0)),  64'h1B02EFFC7072);
        chk("model_k2",  64'(ref_key(KEY_A, 1)),  64'h79AED9DBC9E5);
        chk("model_k16", 64'(ref_key(KEY_A, 15)), 64'hCB3D8B0E17F5);

        repeat (2) @(negedge clk);
        chk("rst_key",   64'(ifc.round_key_dout), 64'h0);
        chk("rst_valid", 64'(ifc.round_key_valid_dout), 64'h0);
        chk("rst_busy",  64'(ifc.busy_dout), 64'h0);
        reset = 1'b0;

        // Encrypt with advance held high.
        @(negedge clk);
        ifc.key_din = KEY_A; ifc.start_strobe_din = 1'b1;
        @(negedge clk);
        ifc.start_strobe_din = 1'b0;
        ifc.key_din = 64'hFFFF_0000_FFFF_0000;
        chk("enc_k1", 64'(ifc.round_key_dout), 64'h1B02EFFC7072);
        ifc.round_advance_din = 1'b1;
        @(negedge clk);
        chk("enc_k2", 64'(ifc.round_key_dout), 64'h79AED9DBC9E5);
        repeat (14) @(negedge clk);
        chk("enc_k16", 64'(ifc.round_key_dout), 64'hCB3D8B0E17F5);
        chk("enc_r16", 64'(ifc.round_number_dout), 64'd15);
        @(negedge clk);
        chk("enc_done", 64'(ifc.done_dout), 64'd1);
        chk("enc_done_valid", 64'(ifc.round_key_valid_dout), 64'd0);
        // Back-to-back start in the done cycle.
        ifc.round_advance_din = 1'b0;
        ifc.key_din = KEY_A; ifc.start_strobe_din = 1'b1;
        @(negedge clk);
        ifc.start_strobe_din = 1'b0;
        chk("b2b_k1", 64'(ifc.round_key_dout), 64'h1B02EFFC7072);
        chk("b2b_valid", 64'(ifc.round_key_valid_dout), 64'd1);

        // Stall at round 3, with a start attempt while busy.
        ifc.round_advance_din = 1'b1;
        repeat (3) @(negedge clk);
        ifc.round_advance_din = 1'b0;
        ifc.key_din = 64'h0123456789ABCDEF; ifc.start_strobe_din = 1'b1;
        repeat (5) @(negedge clk);
        ifc.start_strobe_din = 1'b0;
        chk("stall_key", 64'(ifc.round_key_dout), 64'(ref_key(KEY_A, 3)));
        chk("stall_rnd", 64'(ifc.round_number_dout), 64'd3);
        chk("stall_valid", 64'(ifc.round_key_valid_dout), 64'd1);

        // Reset at round 7: no done pulse, outputs zero.
        ifc.round_advance_din = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_rnd", 64'(ifc.round_number_dout), 64'd7);
        ifc.round_advance_din = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_done", 64'(ifc.done_dout), 64'd0);
        chk("midrst_key", 64'(ifc.round_key_dout), 64'h0);
        chk("midrst_busy", 64'(ifc.busy_dout), 64'd0);

        // Advance in IDLE, then start+advance together.
        ifc.round_advance_din = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_adv_busy", 64'(ifc.busy_dout), 64'd0);
        ifc.key_din = KEY_A; ifc.start_strobe_din = 1'b1;
        @(negedge clk);
        ifc.start_strobe_din = 1'b0; ifc.round_advance_din = 1'b0;
        chk("st_adv_rnd", 64'(ifc.round_number_dout), 64'd0);
        chk("st_adv_k1", 64'(ifc.round_key_dout), 64'h1B02EFFC7072);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

`ifdef DES_DECRYPT_EN
        // Reverse-order keys.
        ifc.key_din = KEY_A; ifc.start_strobe_din = 1'b1; ifc.decrypt_din = 1'b1;
        @(negedge clk);
        ifc.start_strobe_din = 1'b0; ifc.decrypt_din = 1'b0;
        chk("dec_first", 64'(ifc.round_key_dout), 64'hCB3D8B0E17F5);
        ifc.round_advance_din = 1'b1;
        repeat (15) @(negedge clk);
        chk("dec_last", 64'(ifc.round_key_dout), 64'h1B02EFFC7072);
        chk("dec_rnd", 64'(ifc.round_number_dout), 64'd15);
        @(negedge clk);
        chk("dec_done", 64'(ifc.done_dout), 64'd1);
        ifc.round_advance_din = 1'b0;
`endif

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset                 = ($urandom_range(0, 299) == 0);
            ifc.start_strobe_din  = ($urandom_range(0, 7) == 0);
            ifc.round_advance_din = ($urandom_range(0, 3) != 0);
            ifc.key_din           = {$urandom, $urandom};
`ifdef DES_DECRYPT_EN
            ifc.decrypt_din       = $urandom_range(0, 1) != 0;
`endif
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
